// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned REGBITS_DEFAULT = 5;
  localparam int unsigned PERF_W          = 32;

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    HALTED
  } hz_state_t;

  typedef logic [REGBITS_DEFAULT-1:0] regbits_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags an ID-stage read of the register a load in EX
// is about to write. Register $0 is hardwired, so it never creates a hazard.
module load_use_detect #(
  parameter int unsigned REGBITS = 5
) (
  input  logic [REGBITS-1:0] ifid_rs_i,
  input  logic [REGBITS-1:0] ifid_rt_i,
  input  logic               ifid_uses_rt_i,
  input  logic [REGBITS-1:0] idex_wsel_i,
  input  logic               idex_dren_i,
  output logic               lu_stall_o
);

  logic rs_match;
  logic rt_match;

  // Compare the pending load destination against both ID-stage sources.
  always_comb begin
    rs_match   = (idex_wsel_i == ifid_rs_i);
    rt_match   = ifid_uses_rt_i && (idex_wsel_i == ifid_rt_i);
    lu_stall_o = idex_dren_i && (idex_wsel_i != '0) && (rs_match || rt_match);
  end

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, memory wait,
// control redirect and the halt/dcache-writeback sequence.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned REGBITS = 5
`ifdef HAZARD_PERF_EN
  , parameter int unsigned PERF_W = hazard_pkg::PERF_W
`endif
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               ihit,
  input  logic               dhit,
  input  logic               exmem_dREN,
  input  logic               exmem_dWEN,
  input  logic               idex_dREN,
  input  logic [REGBITS-1:0] idex_wsel,
  input  logic [REGBITS-1:0] ifid_rs,
  input  logic [REGBITS-1:0] ifid_rt,
  input  logic               ifid_uses_rt,
  input  logic               idex_taken,
  input  logic               memwb_halt,
  input  logic               flush_done,
  output logic               pc_en,
  output logic               ifid_en,
  output logic               idex_en,
  output logic               exmem_en,
  output logic               memwb_en,
  output logic               ifid_flush,
  output logic               idex_flush,
  output logic               exmem_flush,
  output logic               flush_req,
  output logic               halt
`ifdef HAZARD_PERF_EN
  , output logic [PERF_W-1:0] stall_cycles
  , output logic [PERF_W-1:0] bubble_count
  , output logic [PERF_W-1:0] redirect_count
`endif
);

  hz_state_t state_q, state_d;
  logic      halt_q, halt_d;
  logic      flush_req_q, flush_req_d;
  logic      lu_stall;
  logic      dmem_wait;

  load_use_detect #(
    .REGBITS(REGBITS)
  ) u_load_use_detect (
    .ifid_rs_i      (ifid_rs),
    .ifid_rt_i      (ifid_rt),
    .ifid_uses_rt_i (ifid_uses_rt),
    .idex_wsel_i    (idex_wsel),
    .idex_dren_i    (idex_dREN),
    .lu_stall_o     (lu_stall)
  );

  assign dmem_wait = (exmem_dREN || exmem_dWEN) && !dhit;

  // State and registered status outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RUN;
      halt_q      <= 1'b0;
      flush_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      halt_q      <= halt_d;
      flush_req_q <= flush_req_d;
    end
  end

  // Next state plus combinational enables/flushes, evaluated in hazard priority order.
  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (RST) begin
      state_d     = RUN;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (memwb_halt) begin
            state_d     = FLUSH;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
          end else if (dmem_wait) begin
            // whole pipe frozen: defaults already hold every latch
          end else if (idex_taken && ihit) begin
            pc_en      = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
          end else if (idex_taken) begin
            // keep the branch in EX so its target is re-presented once fetch hits
            ifid_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_en    = 1'b1;
          end else if (lu_stall) begin
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
          end else if (!ihit) begin
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
          end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
          end
        end
        FLUSH: begin
          if (flush_done) begin
            state_d = HALTED;
          end
        end
        HALTED: begin
        end
        default: state_d = RUN;
      endcase
    end
    flush_req_d = (state_d == FLUSH);
    halt_d      = (state_d == HALTED);
  end

  assign flush_req = flush_req_q;
  assign halt      = halt_q;

`ifdef HAZARD_PERF_EN
  logic run_active;
  logic stall_inc;
  logic bubble_inc;
  logic redirect_inc;
  logic [PERF_W-1:0] stall_q, bubble_q, redirect_q;

  assign run_active   = !RST && (state_q == RUN);
  assign stall_inc    = run_active && !pc_en;
  assign bubble_inc   = run_active && !memwb_halt && !dmem_wait && !idex_taken && lu_stall;
  assign redirect_inc = run_active && !memwb_halt && !dmem_wait && idex_taken && ihit;

  // Saturating event counters; they only move in RUN, so they freeze once halted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_q    <= '0;
      bubble_q   <= '0;
      redirect_q <= '0;
    end else begin
      if (stall_inc && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
      if (bubble_inc && (bubble_q != '1)) begin
        bubble_q <= bubble_q + 1'b1;
      end
      if (redirect_inc && (redirect_q != '1)) begin
        redirect_q <= redirect_q + 1'b1;
      end
    end
  end

  assign stall_cycles   = stall_q;
  assign bubble_count   = bubble_q;
  assign redirect_count = redirect_q;
`endif

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Consumes hit signals, stage-latch hazard info and halt status.
- Drives per-latch enable/flush and the PC enable.
- Owns the halt sequence, including the dcache writeback handshake, and works alongside the forwarding logic.
- Forwarding covers ALU-to-ALU dependencies; this block covers load-use, memory wait, control redirect and halt.

Parameters:
REGBITS, 5, register-select width
PERF_W, 32, width of perf counters (used only under HAZARD_PERF_EN)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  synchronous, active-high reset
ihit  in  1  imem fetch valid this cycle
dhit  in  1  dmem access complete this cycle
exmem_dREN  in  1  load in MEM stage
exmem_dWEN  in  1  store in MEM stage
idex_dREN  in  1  load in EX stage
idex_wsel  in  REGBITS  destination of EX-stage instruction
ifid_rs  in  REGBITS  rs of ID-stage instruction
ifid_rt  in  REGBITS  rt of ID-stage instruction
ifid_uses_rt  in  1  ID instruction reads rt
idex_taken  in  1  branch/jump resolved taken in EX
memwb_halt  in  1  halt opcode reached WB latch
flush_done  in  1  dcache writeback complete
pc_en  out  1  PC may update
ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables
ifid_flush, idex_flush, exmem_flush  out  1 each  load a bubble (overrides enable)
flush_req  out  1  request dcache writeback
halt  out  1  CPU halted, sticky

Behaviour:
- FSM states: RUN, FLUSH, HALTED. Reset enters RUN.
- Registered outputs: flush_req and halt are registered; all other outputs are combinational from state and inputs.
- Reset values: halt=0, flush_req=0. In the reset cycle all enables are 0 and all flushes are 1.
- RUN priority, highest first:
  1. memwb_halt=1:
     - next state FLUSH.
     - This cycle: all enables 0, ifid_flush=idex_flush=exmem_flush=1. Younger instructions never commit.
  2. dmem wait, (exmem_dREN|exmem_dWEN)&!dhit:
     - all enables and pc_en 0, no flushes; whole pipe freezes.
  3. Redirect, idex_taken:
     - with ihit=1: pc_en=1, ifid_flush=1, idex_flush=1, exmem_en=memwb_en=1.
     - with ihit=0: pc_en=0, idex_en=0, ifid_flush=1, exmem_flush=1. The branch is held in EX until ihit.
  4. Load-use, idex_dREN & idex_wsel!=0 & (idex_wsel==ifid_rs | ifid_uses_rt & idex_wsel==ifid_rt):
     - pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1.
     - Exactly one bubble; the following cycle is resolved by forwarding.
  5. Fetch wait, !ihit:
     - pc_en=0, ifid_flush=1, remaining stages advance.
  6. Otherwise: all enables 1, all flushes 0, pc_en=ihit.
- Register $0 never causes a load-use stall.
- FLUSH:
  - flush_req=1 from the first FLUSH cycle; all enables 0.
  - flush_done=1 → HALTED on the next edge; flush_req deasserts the same edge.
- HALTED:
  - halt=1; all enables 0; flush_req=0.
  - Exits only on RST.
- RST asserted in any state, including mid-FLUSH: next edge enters RUN with halt=0 and flush_req=0.
- A flush_done seen outside FLUSH is ignored.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - Adds outputs stall_cycles, bubble_count, redirect_count, each PERF_W wide.
  - stall_cycles increments every RUN cycle with pc_en=0.
  - bubble_count increments every load-use bubble.
  - redirect_count increments per idex_taken accepted with ihit.
  - All counters clear on RST, saturate at all-ones, and freeze in HALTED.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- hazard_pkg holds typedef enum hz_state_t {RUN, FLUSH, HALTED}, typedef logic [REGBITS-1:0] regbits_t, and the PERF_W constant.
- One combinational sub-module, load_use_detect (ifid_rs/rt, ifid_uses_rt, idex_wsel, idex_dREN → lu_stall), instantiated once.

Test Plan:
- Load-use: lw $5 in EX (idex_dREN=1, idex_wsel=5), ID reads rs=5, ihit=1, dhit=1 → one cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle normal.
- Load to $0: same stimulus with idex_wsel=0 → no stall.
- Store miss: exmem_dWEN=1, dhit=0 for 3 cycles alongside idex_taken=1 → all enables 0 for 3 cycles, no flush. On dhit=1: redirect with ifid_flush=idex_flush=1, pc_en=1.
- Branch, fetch miss: idex_taken=1, ihit=0 for 2 cycles → idex_en=0, exmem_flush=1, ifid_flush=1. Then ihit=1 → pc_en=1, idex_flush=1.
- Halt: memwb_halt=1 → exmem_flush=1, flush_req=1 next cycle; hold flush_done=0 for 5 cycles, then 1 → halt=1, flush_req=0, enables stay 0 for 10 more cycles.
- Reset mid-FLUSH: RST=1 while flush_req=1 → next edge halt=0, flush_req=0, state RUN. With HAZARD_PERF_EN, counters read 0.
